// File: rtl/warp_regfile_banked.sv
// Banked per-warp vector register file: NUM_BANKS swizzled 1R1W banks, two-operand reads,
// same-bank conflict serialisation, lane-masked write-first bypass and a conflict counter.
module warp_regfile_banked #(
  parameter int NUM_THREADS = 8,
  parameter int DWIDTH      = 32,
  parameter int NUM_WARPS   = 8,
  parameter int NUM_REGS    = 16,
  parameter int NUM_BANKS   = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]  rd_warp,
  input  logic [$clog2(NUM_REGS)-1:0]   rd_a_reg,
  input  logic [$clog2(NUM_REGS)-1:0]   rd_b_reg,
  output logic                          rd_out_valid,
  output logic [NUM_THREADS*DWIDTH-1:0] rd_a_data,
  output logic [NUM_THREADS*DWIDTH-1:0] rd_b_data,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_WARPS)-1:0]  wr_warp,
  input  logic [$clog2(NUM_REGS)-1:0]   wr_reg,
  input  logic [NUM_THREADS-1:0]        wr_mask,
  input  logic [NUM_THREADS*DWIDTH-1:0] wr_data,
  output logic [CNT_W-1:0]              conflict_cnt
);

  localparam int WW    = $clog2(NUM_WARPS);
  localparam int RW    = $clog2(NUM_REGS);
  localparam int BW    = $clog2(NUM_BANKS);
  localparam int DEPTH = NUM_WARPS * NUM_REGS / NUM_BANKS;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = NUM_THREADS * DWIDTH;

  typedef enum logic [0:0] {ISSUE = 1'b0, CONFLICT = 1'b1} state_t;

  // Swizzle consecutive registers of a warp across banks, offset by warp id.
  function automatic logic [BW-1:0] bank_of(input logic [WW-1:0] w, input logic [RW-1:0] r);
    logic [RW-1:0] s;
    s = r + RW'(w);
    return s[BW-1:0];
  endfunction

  function automatic logic [AW-1:0] row_of(input logic [WW-1:0] w, input logic [RW-1:0] r);
    return AW'({w, r} >> BW);
  endfunction

  logic [LW-1:0] mem [NUM_BANKS][DEPTH];

  state_t            state_r;
  logic [BW-1:0]     b_bank_r;
  logic [AW-1:0]     b_row_r;
  logic [LW-1:0]     a_hold_r;

  logic [BW-1:0]     a_bank_s, b_bank_s, wr_bank_s, pb_bank_s;
  logic [AW-1:0]     a_row_s, b_row_s, wr_row_s, pb_row_s;
  logic              conflict_s, accept_s, hit_a_s, hit_b_s;
  logic [LW-1:0]     a_word_s, b_word_s;

  // Address mapping, conflict detection and B-port address selection.
  always_comb begin
    a_bank_s   = bank_of(rd_warp, rd_a_reg);
    b_bank_s   = bank_of(rd_warp, rd_b_reg);
    a_row_s    = row_of(rd_warp, rd_a_reg);
    b_row_s    = row_of(rd_warp, rd_b_reg);
    wr_bank_s  = bank_of(wr_warp, wr_reg);
    wr_row_s   = row_of(wr_warp, wr_reg);
    conflict_s = (a_bank_s == b_bank_s) && (rd_a_reg != rd_b_reg);
    accept_s   = rd_valid && rd_ready;
    if (state_r == CONFLICT) begin
      pb_bank_s = b_bank_r;
      pb_row_s  = b_row_r;
    end else begin
      pb_bank_s = b_bank_s;
      pb_row_s  = b_row_s;
    end
    hit_a_s = wr_en && (wr_bank_s == a_bank_s) && (wr_row_s == a_row_s);
    hit_b_s = wr_en && (wr_bank_s == pb_bank_s) && (wr_row_s == pb_row_s);
  end

  // Bank reads with write-first merge on lanes being written this cycle.
  always_comb begin
    a_word_s = mem[a_bank_s][a_row_s];
    b_word_s = mem[pb_bank_s][pb_row_s];
    for (int i = 0; i < NUM_THREADS; i++) begin
      a_word_s[i*DWIDTH +: DWIDTH] = (hit_a_s && wr_mask[i]) ? wr_data[i*DWIDTH +: DWIDTH]
                                                              : a_word_s[i*DWIDTH +: DWIDTH];
      b_word_s[i*DWIDTH +: DWIDTH] = (hit_b_s && wr_mask[i]) ? wr_data[i*DWIDTH +: DWIDTH]
                                                              : b_word_s[i*DWIDTH +: DWIDTH];
    end
  end

  // Lane-masked writeback; the array is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (wr_en && wr_mask[i]) begin
        mem[wr_bank_s][wr_row_s][i*DWIDTH +: DWIDTH] <= wr_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Issue/conflict FSM with registered handshake, operand outputs and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ISSUE;
      rd_ready     <= 1'b1;
      rd_out_valid <= 1'b0;
      rd_a_data    <= {LW{1'b0}};
      rd_b_data    <= {LW{1'b0}};
      conflict_cnt <= {CNT_W{1'b0}};
      b_bank_r     <= {BW{1'b0}};
      b_row_r      <= {AW{1'b0}};
      a_hold_r     <= {LW{1'b0}};
    end else begin
      case (state_r)
        ISSUE: begin
          if (accept_s && conflict_s) begin
            a_hold_r     <= a_word_s;
            b_bank_r     <= b_bank_s;
            b_row_r      <= b_row_s;
            state_r      <= CONFLICT;
            rd_ready     <= 1'b0;
            rd_out_valid <= 1'b0;
            if (conflict_cnt != {CNT_W{1'b1}}) begin
              conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              conflict_cnt <= conflict_cnt;
            end
          end else if (accept_s) begin
            rd_a_data    <= a_word_s;
            rd_b_data    <= b_word_s;
            rd_out_valid <= 1'b1;
          end else begin
            rd_out_valid <= 1'b0;
          end
        end
        CONFLICT: begin
          // A was captured at acceptance; B's bank is free now.
          rd_a_data    <= a_hold_r;
          rd_b_data    <= b_word_s;
          rd_out_valid <= 1'b1;
          rd_ready     <= 1'b1;
          state_r      <= ISSUE;
        end
        default: begin
          state_r      <= ISSUE;
          rd_ready     <= 1'b1;
          rd_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_warp_regfile_banked.sv
// Self-checking bench for warp_regfile_banked: directed scenarios plus randomized traffic
// against a register-array reference model with write-first and conflict timing rules.
module tb_warp_regfile_banked;
  localparam int NT = 8, DW = 32, NW = 8, NR = 16, NB = 4, CW = 16;
  localparam int LW = NT * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_valid = 1'b0, rd_ready, rd_out_valid;
  logic [2:0]    rd_warp = 3'd0, wr_warp = 3'd0;
  logic [3:0]    rd_a_reg = 4'd0, rd_b_reg = 4'd0, wr_reg = 4'd0;
  logic [LW-1:0] rd_a_data, rd_b_data, wr_data = '0;
  logic          wr_en = 1'b0;
  logic [NT-1:0] wr_mask = '0;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  warp_regfile_banked dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_warp(rd_warp), .rd_a_reg(rd_a_reg), .rd_b_reg(rd_b_reg),
    .rd_out_valid(rd_out_valid), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_warp(wr_warp), .wr_reg(wr_reg), .wr_mask(wr_mask),
    .wr_data(wr_data), .conflict_cnt(conflict_cnt)
  );

  // Reference model: architectural registers per warp per lane
  logic [DW-1:0] model [NW][NR][NT];
  int            n_cmp = 0, n_err = 0;
  bit            m_busy = 1'b0, exp_valid = 1'b0, exp_ready = 1'b1;
  int            pw, pb;
  logic [LW-1:0] pend_a, exp_a = '0, exp_b = '0;
  logic [CW-1:0] exp_cnt = '0;

  function automatic logic [LW-1:0] mword(input int w, input int r);
    logic [LW-1:0] v;
    for (int i = 0; i < NT; i++) v[i*DW +: DW] = model[w][r][i];
    return v;
  endfunction

  function automatic logic [LW-1:0] lanes_idx(input logic [DW-1:0] base);
    logic [LW-1:0] v;
    for (int i = 0; i < NT; i++) v[i*DW +: DW] = base + DW'(i);
    return v;
  endfunction

  function automatic logic [LW-1:0] lanes_split(input logic [NT-1:0] m, input logic [LW-1:0] hi,
                                                 input logic [LW-1:0] lo);
    logic [LW-1:0] v;
    for (int i = 0; i < NT; i++) v[i*DW +: DW] = m[i] ? hi[i*DW +: DW] : lo[i*DW +: DW];
    return v;
  endfunction

  // Drive one cycle, advance the model and derive the outputs expected after the edge.
  task automatic cyc(input bit rv, input int w, input int a, input int b, input bit we,
                     input int ww, input int wr, input logic [NT-1:0] m, input logic [LW-1:0] wd);
    rd_valid = rv; rd_warp = 3'(w); rd_a_reg = 4'(a); rd_b_reg = 4'(b);
    wr_en = we; wr_warp = 3'(ww); wr_reg = 4'(wr); wr_mask = m; wr_data = wd;
    if (we) for (int i = 0; i < NT; i++) if (m[i]) model[ww][wr][i] = wd[i*DW +: DW];
    exp_valid = 1'b0;
    if (m_busy) begin
      exp_a = pend_a; exp_b = mword(pw, pb); exp_valid = 1'b1; m_busy = 1'b0;
    end else if (rv) begin
      if (((a + w) % NB == (b + w) % NB) && a != b) begin
        pend_a = mword(w, a); pw = w; pb = b; m_busy = 1'b1;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end else begin
        exp_a = mword(w, a); exp_b = mword(w, b); exp_valid = 1'b1;
      end
    end
    exp_ready = !m_busy;
    @(posedge clk); #1;
    rd_valid = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rd_ready); end
    n_cmp++; if (rd_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rd_out_valid); end
    n_cmp++; if (rd_a_data !== '0) begin n_err++; $display("FAIL reset_a: got %h want 0", rd_a_data); end
    n_cmp++; if (rd_b_data !== '0) begin n_err++; $display("FAIL reset_b: got %h want 0", rd_b_data); end
    n_cmp++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
  endtask

  task automatic test_init;
    logic [LW-1:0] wd;
    for (int w = 0; w < NW; w++) for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NT; i++) wd[i*DW +: DW] = $urandom;
      cyc(1'b0, 0, 0, 0, 1'b1, w, r, 8'hFF, wd);
    end
    n_cmp++; if (rd_out_valid !== 1'b0) begin n_err++; $display("FAIL init_valid: got %b want 0", rd_out_valid); end
  endtask

  task automatic test_basic;
    cyc(1'b0, 0, 0, 0, 1'b1, 2, 5, 8'hFF, lanes_idx(32'h100));
    n_cmp++; if (rd_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", rd_out_valid); end
    cyc(1'b1, 2, 5, 6, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", rd_out_valid); end
    n_cmp++; if (rd_a_data !== lanes_idx(32'h100)) begin n_err++; $display("FAIL basic_a: got %h want %h", rd_a_data, lanes_idx(32'h100)); end
    n_cmp++; if (rd_b_data !== exp_b) begin n_err++; $display("FAIL basic_b: got %h want %h", rd_b_data, exp_b); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", rd_ready); end
  endtask

  task automatic test_conflict;
    cyc(1'b1, 0, 1, 5, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL conf_ready: got %b want 0", rd_ready); end
    n_cmp++; if (rd_out_valid !== 1'b0) begin n_err++; $display("FAIL conf_early: got %b want 0", rd_out_valid); end
    n_cmp++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL conf_cnt: got %0d want 1", conflict_cnt); end
    cyc(1'b0, 0, 0, 0, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_out_valid !== 1'b1) begin n_err++; $display("FAIL conf_valid: got %b want 1", rd_out_valid); end
    n_cmp++; if (rd_a_data !== exp_a) begin n_err++; $display("FAIL conf_a: got %h want %h", rd_a_data, exp_a); end
    n_cmp++; if (rd_b_data !== exp_b) begin n_err++; $display("FAIL conf_b: got %h want %h", rd_b_data, exp_b); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL conf_ready2: got %b want 1", rd_ready); end
    cyc(1'b1, 0, 5, 5, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_out_valid !== 1'b1) begin n_err++; $display("FAIL same_valid: got %b want 1", rd_out_valid); end
    n_cmp++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL same_cnt: got %0d want 1", conflict_cnt); end
    n_cmp++; if (rd_b_data !== exp_a) begin n_err++; $display("FAIL same_b: got %h want %h", rd_b_data, exp_a); end
  endtask

  task automatic test_mask;
    logic [LW-1:0] want;
    cyc(1'b0, 0, 0, 0, 1'b1, 1, 3, 8'hFF, {NT{32'h11111111}});
    cyc(1'b0, 0, 0, 0, 1'b1, 1, 3, 8'h0F, {NT{32'hAAAAAAAA}});
    cyc(1'b1, 1, 3, 0, 1'b0, 0, 0, 8'h00, '0);
    want = {{4{32'h11111111}}, {4{32'hAAAAAAAA}}};
    n_cmp++; if (rd_a_data !== want) begin n_err++; $display("FAIL mask_a: got %h want %h", rd_a_data, want); end
  endtask

  task automatic test_bypass;
    logic [LW-1:0] want;
    cyc(1'b0, 0, 0, 0, 1'b1, 3, 7, 8'hFF, lanes_idx(32'h55550000));
    cyc(1'b1, 3, 7, 0, 1'b1, 3, 7, 8'hF0, {NT{32'hDEADBEEF}});
    want = lanes_split(8'hF0, {NT{32'hDEADBEEF}}, lanes_idx(32'h55550000));
    n_cmp++; if (rd_out_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid: got %b want 1", rd_out_valid); end
    n_cmp++; if (rd_a_data !== want) begin n_err++; $display("FAIL byp_issue_a: got %h want %h", rd_a_data, want); end
    cyc(1'b0, 0, 0, 0, 1'b1, 3, 7, 8'hFF, lanes_idx(32'h77770000));
    cyc(1'b1, 3, 3, 7, 1'b0, 0, 0, 8'h00, '0);
    cyc(1'b0, 0, 0, 0, 1'b1, 3, 7, 8'hF0, {NT{32'hDEADBEEF}});
    want = lanes_split(8'hF0, {NT{32'hDEADBEEF}}, lanes_idx(32'h77770000));
    n_cmp++; if (rd_b_data !== want) begin n_err++; $display("FAIL byp_conf_b: got %h want %h", rd_b_data, want); end
    n_cmp++; if (rd_a_data !== exp_a) begin n_err++; $display("FAIL byp_conf_a: got %h want %h", rd_a_data, exp_a); end
    cyc(1'b1, 3, 3, 7, 1'b1, 3, 7, 8'hFF, lanes_idx(32'h99990000));
    cyc(1'b0, 0, 0, 0, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_b_data !== lanes_idx(32'h99990000)) begin n_err++; $display("FAIL byp_accept_b: got %h want %h", rd_b_data, lanes_idx(32'h99990000)); end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 0, 1, 5, 1'b0, 0, 0, 8'h00, '0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", conflict_cnt); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", rd_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_busy = 1'b0; exp_cnt = '0; exp_a = '0; exp_b = '0;
    n_cmp++; if (rd_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", rd_out_valid); end
    cyc(1'b0, 0, 0, 0, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_late: got %b want 0", rd_out_valid); end
    cyc(1'b1, 2, 5, 6, 1'b0, 0, 0, 8'h00, '0);
    n_cmp++; if (rd_a_data !== lanes_idx(32'h100)) begin n_err++; $display("FAIL rmid_keep_a: got %h want %h", rd_a_data, lanes_idx(32'h100)); end
    n_cmp++; if (rd_b_data !== exp_b) begin n_err++; $display("FAIL rmid_keep_b: got %h want %h", rd_b_data, exp_b); end
  endtask

  task automatic test_random;
    logic [LW-1:0] wd;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NT; i++) wd[i*DW +: DW] = $urandom;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, NW-1), $urandom_range(0, NR-1),
          $urandom_range(0, NR-1), $urandom_range(0, 1) == 1, $urandom_range(0, NW-1),
          $urandom_range(0, NR-1), NT'($urandom), wd);
      n_cmp++; if (rd_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, rd_ready, exp_ready); end
      n_cmp++; if (rd_out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, rd_out_valid, exp_valid); end
      n_cmp++; if (conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, conflict_cnt, exp_cnt); end
      n_cmp++; if (rd_a_data !== exp_a) begin n_err++; $display("FAIL rnd_a[%0d]: got %h want %h", n, rd_a_data, exp_a); end
      n_cmp++; if (rd_b_data !== exp_b) begin n_err++; $display("FAIL rnd_b[%0d]: got %h want %h", n, rd_b_data, exp_b); end
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_basic;
    test_conflict;
    test_mask;
    test_bypass;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
